write_port_sel_pipe: RTL and testbench
======================================

# write_port_sel_pipe

Parametrised register-file write-port selector with a built-in write-back delay line and destination scoreboard.

- Each cycle it selects the destination register for the instruction leaving decode. Sources are R1, R2, or the fixed link register used by jump-and-link.
- It carries that destination through DEPTH pipeline stages to the register-file write port.
- It flags read-after-write hazards for two source operands against every in-flight destination.
- It sits between the decoder/control unit and the register file, and replaces the single-cycle two-way write-port mux.

## Interface

Parameters:
- ADDR_W, default 5: register address width.
- DEPTH, default 3: pipeline stages from decode to write-back; legal range 1..8.
- LINK_REG, default 31: destination address used when the link source is selected.

Ports (clock and reset first):
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  1  a decoded instruction is presented this cycle.
- sel_in  input  2  destination source: 00 = R1, 01 = R2, 10 = LINK_REG, 11 = no write.
- R1  input  ADDR_W  first candidate destination field.
- R2  input  ADDR_W  second candidate destination field.
- stall  input  1  hold every stage and ignore valid_in.
- flush  input  1  invalidate every stage.
- query_a  input  ADDR_W  source operand A address to check.
- query_b  input  ADDR_W  source operand B address to check.
- WritePort  output  ADDR_W  register-file write address (tail stage).
- write_en  output  1  register-file write enable.
- hazard_a  output  1  query_a matches an in-flight destination.
- hazard_b  output  1  query_b matches an in-flight destination.
- inflight_count  output  $clog2(DEPTH+1)  number of valid stages.

## Operation

- State: DEPTH entries, each holding a valid bit and an ADDR_W address. Stage 0 is the youngest; stage DEPTH-1 is the tail.
- Capture address: dest = R1 / R2 / LINK_REG per sel_in.
- Capture valid: entry valid = valid_in & (sel_in != 11) & (dest != 0).
  - Writes to register 0 are suppressed at capture and never create a hazard.
- Advance (no stall, no flush): stage[0] <= new entry; stage[i] <= stage[i-1] for i = 1..DEPTH-1. The tail entry is retired at the same edge.
- Stall (flush low): all stages hold; valid_in, sel_in, R1 and R2 are ignored.
- Flush: all valid bits cleared at the edge. Flush has priority over stall and valid_in. Addresses may keep stale values.
- WritePort = tail address.
- write_en = tail valid & ~stall.
  - During a stall the tail does not write. It writes once, in the first unstalled cycle.
- hazard_x = (query_x != 0) & OR over i of (stage[i].valid & stage[i].addr == query_x). This covers all stages, including the tail.
- inflight_count = popcount of the stage valid bits.
- All outputs are combinational from registered state, except:
  - write_en also depends on stall;
  - hazard_x also depends on query_x.
- Reset: all valid bits and addresses go to 0, so WritePort = 0, write_en = 0, hazard_a = hazard_b = 0, inflight_count = 0.
  - Reset takes effect immediately and asynchronously, including mid-stream and during a stall.

## Timing

- Latency: an entry captured at edge k sits at the tail after edge k+DEPTH-1. write_en is high in the cycle after that edge, i.e. DEPTH cycles after presentation when there are no stalls. For DEPTH = 1, write_en is high in the cycle right after capture.
- Throughput: one entry per unstalled cycle, with no bubbles inserted.
- Each stall cycle adds exactly one cycle of latency to every in-flight entry.
- Flush in the same cycle as an unstalled tail: write_en is still high in that cycle. The tail write completes, and the pipe is empty from the next cycle.
- Flush and valid_in in the same cycle: the new entry is dropped.
- Hazards see a new entry from the cycle after its capture edge. The entry drops out of the hazard check once it has been retired from the tail.
- Duplicate destinations in several stages: hazard stays high until the last matching entry retires.

## Test plan

- Reset and basic path (DEPTH=3):
  - Release reset → all outputs 0.
  - Present valid_in=1, sel_in=00, R1=7 once → WritePort=7, write_en=1 exactly 3 cycles later, for one cycle. inflight_count goes 1,1,1,0.
- Source selection: back-to-back entries sel_in=01 (R2=12), 10, 00 (R1=0), 11 → successive tail cycles give WritePort=12 with write_en=1, WritePort=31 with write_en=1, then two cycles with write_en=0.
- Stall: capture R1=5, then raise stall for 2 cycles while the entry is in stage 1 → write_en rises at cycle 5 instead of 3. Inputs presented during the stall are not captured.
- Hazard: capture dest 9, then hold query_a=9, query_b=0 → hazard_a=1 for exactly 3 cycles, hazard_b=0 throughout. With query_a=0 and dest 0 captured → no hazard.
- Flush: fill 3 entries (3, 4, 5), assert flush for 1 cycle while dest 3 is at the tail →
  - write_en=1, WritePort=3 in the flush cycle;
  - write_en=0 afterwards;
  - inflight_count=0 and hazards clear on the next cycle.
- Async reset mid-stream: assert reset between edges with 2 entries in flight → outputs go to 0 before the next edge, and no write appears after release.

Source files
------------

// File: rtl/write_port_sel_pipe.sv
// Register-file write-port selector with a write-back delay line.
// Also tracks in-flight destinations to flag read-after-write hazards.
module write_port_sel_pipe #(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int LINK_REG = 31
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic [1:0]                   sel_in,
  input  logic [ADDR_W-1:0]            R1,
  input  logic [ADDR_W-1:0]            R2,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [ADDR_W-1:0]            query_a,
  input  logic [ADDR_W-1:0]            query_b,
  output logic [ADDR_W-1:0]            WritePort,
  output logic                         write_en,
  output logic                         hazard_a,
  output logic                         hazard_b,
  output logic [$clog2(DEPTH+1)-1:0]   inflight_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LINK = ADDR_W'(LINK_REG);

  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0]            dest;
  logic                         new_vld;

  // Pick the destination for the instruction leaving decode.
  always_comb begin
    dest = '0;
    unique case (sel_in)
      2'b00:   dest = R1;
      2'b01:   dest = R2;
      2'b10:   dest = LINK;
      default: dest = '0;
    endcase
    new_vld = valid_in && (sel_in != 2'b11) && (dest != '0);
  end

  // Next state: flush clears valids, stall holds, otherwise shift.
  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    if (flush) begin
      vld_d = '0;
    end else if (!stall) begin
      vld_d[0]  = new_vld;
      addr_d[0] = dest;
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i]  = vld_q[i-1];
        addr_d[i] = addr_q[i-1];
      end
    end
  end

  // Stage registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      addr_q <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
    end
  end

  // Tail write, hazard match and occupancy from registered state.
  always_comb begin
    WritePort      = addr_q[DEPTH-1];
    write_en       = vld_q[DEPTH-1] & ~stall;
    hazard_a       = 1'b0;
    hazard_b       = 1'b0;
    inflight_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && addr_q[i] == query_a) hazard_a = 1'b1;
      if (vld_q[i] && addr_q[i] == query_b) hazard_b = 1'b1;
      inflight_count = inflight_count + CW'(vld_q[i]);
    end
    if (query_a == '0) hazard_a = 1'b0;
    if (query_b == '0) hazard_b = 1'b0;
  end

endmodule

// File: tb/tb_write_port_sel_pipe.sv
// Directed bench for write_port_sel_pipe (DEPTH=3, LINK_REG=31).
// Table of per-cycle vectors plus a hand-written async reset sequence.
module tb_write_port_sel_pipe;

  localparam int AW = 5;
  localparam int D  = 3;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [1:0]    sel_in;
  logic [AW-1:0] R1, R2;
  logic          stall, flush;
  logic [AW-1:0] query_a, query_b;
  logic [AW-1:0] WritePort;
  logic          write_en;
  logic          hazard_a, hazard_b;
  logic [CW-1:0] inflight_count;

  always #5 clk = ~clk;

  write_port_sel_pipe #(
    .ADDR_W(AW), .DEPTH(D), .LINK_REG(31)
  ) dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .sel_in(sel_in),
    .R1(R1), .R2(R2),
    .stall(stall), .flush(flush),
    .query_a(query_a), .query_b(query_b),
    .WritePort(WritePort), .write_en(write_en),
    .hazard_a(hazard_a), .hazard_b(hazard_b),
    .inflight_count(inflight_count)
  );

  typedef struct {
    logic          vi;
    logic [1:0]    sel;
    logic [AW-1:0] r1, r2;
    logic          st, fl;
    logic [AW-1:0] qa, qb;
    logic          we;
    logic [AW-1:0] wp;
    logic          ha, hb;
    int            cnt;
  } vec_t;

  vec_t vt[$];
  int   errs   = 0;
  int   checks = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(logic vi, logic [1:0] sel, int r1, int r2,
                     logic st, logic fl, int qa, int qb,
                     logic we, int wp, logic ha, logic hb, int cnt);
    vec_t v;
    v.vi = vi; v.sel = sel;
    v.r1 = AW'(r1); v.r2 = AW'(r2);
    v.st = st; v.fl = fl;
    v.qa = AW'(qa); v.qb = AW'(qb);
    v.we = we; v.wp = AW'(wp);
    v.ha = ha; v.hb = hb; v.cnt = cnt;
    vt.push_back(v);
  endtask

  task automatic idle_in();
    valid_in = 0; sel_in = 2'b11;
    R1 = '0; R2 = '0;
    stall = 0; flush = 0;
    query_a = '0; query_b = '0;
  endtask

  task automatic chk_out(string nm, logic we, int wp,
                         logic ha, logic hb, int cnt);
    chk({nm, " we"}, 32'(write_en), 32'(we));
    if (we) chk({nm, " wp"}, 32'(WritePort), 32'(wp));
    chk({nm, " ha"}, 32'(hazard_a), 32'(ha));
    chk({nm, " hb"}, 32'(hazard_b), 32'(hb));
    chk({nm, " cnt"}, 32'(inflight_count), 32'(cnt));
  endtask

  initial begin
    // vi sel r1 r2 st fl qa qb | we wp ha hb cnt
    // basic path: R1=7
    add(1,2'b00, 7, 0,0,0, 0, 0, 0, 0,0,0,0);
    add(0,2'b11, 0, 0,0,0, 0, 0, 0, 0,0,0,1);
    add(0,2'b11, 0, 0,0,0, 0, 0, 0, 0,0,0,1);
    add(0,2'b11, 0, 0,0,0, 0, 0, 1, 7,0,0,1);
    add(0,2'b11, 0, 0,0,0, 0, 0, 0, 0,0,0,0);
    // source selection: R2=12, link, R1=0, none
    add(1,2'b01, 3,12,0,0, 0, 0, 0, 0,0,0,0);
    add(1,2'b10, 3, 4,0,0, 0, 0, 0, 0,0,0,1);
    add(1,2'b00, 0, 4,0,0, 0, 0, 0, 0,0,0,2);
    add(1,2'b11, 6, 4,0,0, 0, 0, 1,12,0,0,2);
    add(0,2'b11, 0, 0,0,0, 0, 0, 1,31,0,0,1);
    add(0,2'b11, 0, 0,0,0, 0, 0, 0, 0,0,0,0);
    add(0,2'b11, 0, 0,0,0, 0, 0, 0, 0,0,0,0);
    // stall in stage 1, inputs during stall ignored
    add(1,2'b00, 5, 0,0,0, 0, 0, 0, 0,0,0,0);
    add(0,2'b11, 0, 0,0,0, 0, 0, 0, 0,0,0,1);
    add(1,2'b00, 8, 0,1,0, 0, 0, 0, 0,0,0,1);
    add(1,2'b00, 9, 0,1,0, 0, 0, 0, 0,0,0,1);
    add(0,2'b11, 0, 0,0,0, 0, 0, 0, 0,0,0,1);
    add(0,2'b11, 0, 0,0,0, 0, 0, 1, 5,0,0,1);
    // stall with valid tail: write deferred
    add(1,2'b00, 6, 0,0,0, 0, 0, 0, 0,0,0,0);
    add(0,2'b11, 0, 0,0,0, 0, 0, 0, 0,0,0,1);
    add(0,2'b11, 0, 0,0,0, 0, 0, 0, 0,0,0,1);
    add(0,2'b11, 0, 0,1,0, 0, 0, 0, 0,0,0,1);
    add(0,2'b11, 0, 0,0,0, 0, 0, 1, 6,0,0,1);
    add(0,2'b11, 0, 0,0,0, 0, 0, 0, 0,0,0,0);
    // hazard on dest 9 for exactly 3 cycles
    add(1,2'b00, 9, 0,0,0, 9, 0, 0, 0,0,0,0);
    add(0,2'b11, 0, 0,0,0, 9, 0, 0, 0,1,0,1);
    add(0,2'b11, 0, 0,0,0, 9, 0, 0, 0,1,0,1);
    add(0,2'b11, 0, 0,0,0, 9, 0, 1, 9,1,0,1);
    add(0,2'b11, 0, 0,0,0, 9, 0, 0, 0,0,0,0);
    // dest 0 suppressed, query 0 never hazards
    add(1,2'b00, 0, 0,0,0, 0, 0, 0, 0,0,0,0);
    add(0,2'b11, 0, 0,0,0, 0, 0, 0, 0,0,0,0);
    // duplicate dest 10: hazard until last retires
    add(1,2'b01, 0,10,0,0, 0,10, 0, 0,0,0,0);
    add(1,2'b00,10, 0,0,0, 0,10, 0, 0,0,1,1);
    add(0,2'b11, 0, 0,0,0, 0,10, 0, 0,0,1,2);
    add(0,2'b11, 0, 0,0,0, 0,10, 1,10,0,1,2);
    add(0,2'b11, 0, 0,0,0, 0,10, 1,10,0,1,1);
    add(0,2'b11, 0, 0,0,0, 0,10, 0, 0,0,0,0);
    // flush with dest 3 at tail, new entry dropped
    add(1,2'b00, 3, 0,0,0, 0, 0, 0, 0,0,0,0);
    add(1,2'b00, 4, 0,0,0, 0, 0, 0, 0,0,0,1);
    add(1,2'b00, 5, 0,0,0, 0, 0, 0, 0,0,0,2);
    add(1,2'b00, 7, 0,0,1, 4, 0, 1, 3,1,0,3);
    add(0,2'b11, 0, 0,0,0, 4, 0, 0, 0,0,0,0);
    add(0,2'b11, 0, 0,0,0, 0, 0, 0, 0,0,0,0);
    // flush beats stall
    add(1,2'b00,11, 0,0,0, 0, 0, 0, 0,0,0,0);
    add(0,2'b11, 0, 0,1,1,11, 0, 0, 0,1,0,1);
    add(0,2'b11, 0, 0,0,0,11, 0, 0, 0,0,0,0);

    idle_in();
    reset = 1'b1;
    #12;
    chk_out("reset", 0, 0, 0, 0, 0);
    chk("reset wp", 32'(WritePort), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vt[i]) begin
      valid_in = vt[i].vi; sel_in = vt[i].sel;
      R1 = vt[i].r1; R2 = vt[i].r2;
      stall = vt[i].st; flush = vt[i].fl;
      query_a = vt[i].qa; query_b = vt[i].qb;
      @(negedge clk);
      chk_out($sformatf("row%0d", i), vt[i].we, int'(vt[i].wp),
              vt[i].ha, vt[i].hb, vt[i].cnt);
      @(posedge clk); #1;
    end

    // async reset with two entries in flight
    idle_in();
    valid_in = 1; sel_in = 2'b00; R1 = 5'd13;
    @(posedge clk); #1;
    R1 = 5'd14;
    @(posedge clk); #1;
    idle_in();
    query_a = 5'd13; query_b = 5'd14;
    #1;
    chk_out("pre_rst", 0, 0, 1, 1, 2);
    reset = 1'b1;
    #1;
    chk_out("async_rst", 0, 0, 0, 0, 0);
    chk("async_rst wp", 32'(WritePort), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_out($sformatf("post_rst%0d", k), 0, 0, 0, 0, 0);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
